// File: rtl/unpack_pkg.sv
// Shared types and defaults for the unpack_stream receive path.
// Optional preamble tolerance is selected with UNPACK_SYNC_TOL_EN (see unpack_sync_detect).
package unpack_pkg;

  typedef enum logic {
    HUNT    = 1'b0,
    PAYLOAD = 1'b1
  } state_t;

  localparam int unsigned DEF_SIZE_BIT_PACK = 1976;
  localparam int unsigned DEF_SIZE_PREAMBLE = 32;
  localparam logic [31:0] DEF_PREAMBLE      = 32'h1ACFFC1D;

  function automatic int unsigned payload_bits(input int unsigned size_bit_pack,
                                               input int unsigned size_preamble);
    return size_bit_pack - size_preamble;
  endfunction

endpackage

// File: rtl/unpack_sync_detect.sv
// Preamble hunter: serial shift register with clear and a same-cycle match flag.
// UNPACK_SYNC_TOL_EN defined: match within SYNC_TOL bit errors; otherwise exact compare.
module unpack_sync_detect
  import unpack_pkg::*;
#(
  parameter int unsigned                SIZE_PREAMBLE = DEF_SIZE_PREAMBLE,
  parameter logic [SIZE_PREAMBLE-1:0]   PREAMBLE      = SIZE_PREAMBLE'(DEF_PREAMBLE),
  parameter int unsigned                SYNC_TOL      = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic shift_en,
  input  logic bit_in,
  output logic match
);

  // The incoming bit completes the window, so only the older bits are stored;
  // this lets the match fire in the same cycle the last preamble bit arrives.
  logic [SIZE_PREAMBLE-2:0] history;
  logic [SIZE_PREAMBLE-1:0] window;

  assign window = {history, bit_in};

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      history <= '0;
    end else if (shift_en) begin
      history <= window[SIZE_PREAMBLE-2:0];
    end
  end

`ifdef UNPACK_SYNC_TOL_EN
  function automatic int unsigned popcount(input logic [SIZE_PREAMBLE-1:0] v);
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i < SIZE_PREAMBLE; i++) begin
      if (v[i]) n++;
    end
    return n;
  endfunction

  assign match = shift_en && (popcount(window ^ PREAMBLE) <= SYNC_TOL);
`else
  assign match = shift_en && (window == PREAMBLE);
`endif

endmodule

// File: rtl/unpack_stream.sv
// Serial-to-byte unpacker: hunts the preamble, then assembles the payload into bytes.
// Build with UNPACK_SYNC_TOL_EN to accept preambles with up to SYNC_TOL bit errors.
module unpack_stream
  import unpack_pkg::*;
#(
  parameter int unsigned              SIZE_BIT_PACK   = DEF_SIZE_BIT_PACK,
  parameter int unsigned              SIZE_PREAMBLE   = DEF_SIZE_PREAMBLE,
  parameter logic [SIZE_PREAMBLE-1:0] PREAMBLE        = SIZE_PREAMBLE'(DEF_PREAMBLE),
  parameter int unsigned              SIZE_OUTPUT_BIT = 8,
  parameter int unsigned              SYNC_TOL        = 2
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_data,
  input  logic                       i_valid_input,
  output logic                       o_ready,
  output logic [SIZE_OUTPUT_BIT-1:0] o_data,
  output logic                       o_valid,
  input  logic                       i_ready_output,
  output logic                       o_last,
  output logic                       o_lock
);

  localparam int unsigned PAYLOAD_BITS = payload_bits(SIZE_BIT_PACK, SIZE_PREAMBLE);
  localparam int unsigned CNT_W        = $clog2(PAYLOAD_BITS);
  localparam int unsigned ASM_W        = (SIZE_OUTPUT_BIT > 1) ? $clog2(SIZE_OUTPUT_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(PAYLOAD_BITS - 1);
  localparam logic [ASM_W-1:0] BYTE_END = ASM_W'(SIZE_OUTPUT_BIT - 1);

  state_t                     state;
  logic [CNT_W-1:0]           bit_cnt;
  logic [ASM_W-1:0]           asm_cnt;
  logic [SIZE_OUTPUT_BIT-1:0] asm_reg;
  logic [SIZE_OUTPUT_BIT-1:0] asm_next;
  logic                       take;
  logic                       byte_done;
  logic                       match;

  // Stall only when the next bit would complete a byte with nowhere to put it.
  assign o_ready   = !(o_valid && !i_ready_output && state == PAYLOAD && asm_cnt == BYTE_END);
  assign take      = i_valid_input && o_ready;
  assign asm_next  = {asm_reg[SIZE_OUTPUT_BIT-2:0], i_data};
  assign byte_done = take && state == PAYLOAD && asm_cnt == BYTE_END;
  assign o_lock    = (state == PAYLOAD);

  unpack_sync_detect #(
    .SIZE_PREAMBLE (SIZE_PREAMBLE),
    .PREAMBLE      (PREAMBLE),
    .SYNC_TOL      (SYNC_TOL)
  ) u_sync (
    .clk      (i_clk),
    .reset    (i_reset),
    .clear    (state == PAYLOAD),
    .shift_en (take && state == HUNT),
    .bit_in   (i_data),
    .match    (match)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state   <= HUNT;
      bit_cnt <= '0;
      asm_cnt <= '0;
      asm_reg <= '0;
      o_data  <= '0;
      o_valid <= 1'b0;
      o_last  <= 1'b0;
    end else begin
      if (byte_done) begin
        o_data  <= asm_next;
        o_valid <= 1'b1;
        o_last  <= (bit_cnt == LAST_BIT);
      end else if (o_valid && i_ready_output) begin
        o_valid <= 1'b0;
        o_last  <= 1'b0;
      end

      case (state)
        HUNT: begin
          if (match) begin
            state   <= PAYLOAD;
            bit_cnt <= '0;
            asm_cnt <= '0;
            asm_reg <= '0;
          end
        end
        PAYLOAD: begin
          if (take) begin
            asm_reg <= asm_next;
            if (bit_cnt == LAST_BIT) begin
              state   <= HUNT;
              bit_cnt <= '0;
              asm_cnt <= '0;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
              asm_cnt <= (asm_cnt == BYTE_END) ? '0 : asm_cnt + ASM_W'(1);
            end
          end
        end
        default: state <= HUNT;
      endcase
    end
  end

endmodule

// File: tb/tb_unpack_stream.sv
// Directed bench for unpack_stream: framing, backpressure, relock, reset and gapped input.
module tb_unpack_stream;

  localparam logic [31:0] PRE    = 32'h1ACFFC1D;
  localparam int          NBYTES = 243;

  logic       clk = 1'b0;
  logic       i_reset;
  logic       i_data;
  logic       i_valid_input;
  logic       o_ready;
  logic [7:0] o_data;
  logic       o_valid;
  logic       i_ready_output;
  logic       o_last;
  logic       o_lock;

  int   checks = 0;
  int   errors = 0;
  int   stall_left = 0;
  int   stall_acc = 0;
  bit   rand_idle = 1'b0;
  bit   lock_seen = 1'b0;
  logic [8:0] got_q[$];
  logic [8:0] stall_q[$];

  always #5 clk = ~clk;

  unpack_stream dut (
    .i_clk          (clk),
    .i_reset        (i_reset),
    .i_data         (i_data),
    .i_valid_input  (i_valid_input),
    .o_ready        (o_ready),
    .o_data         (o_data),
    .o_valid        (o_valid),
    .i_ready_output (i_ready_output),
    .o_last         (o_last),
    .o_lock         (o_lock)
  );

  function automatic logic [7:0] pay_byte(input int kind, input int i);
    logic [31:0] p;
    p = PRE;
    if (kind == 1 && i < 4) return p[31-8*i -: 8];
    if (kind == 1) return 8'((i * 7 + 3) & 255);
    return 8'(i);
  endfunction

  // One clock: drive, sample just after, then advance to the next falling edge.
  task automatic cycle_step(input logic v, input logic b, output logic acc);
    i_valid_input  = v;
    i_data         = b;
    i_ready_output = (stall_left == 0);
    #1;
    acc = v && o_ready;
    if (o_lock) lock_seen = 1'b1;
    if (o_valid && i_ready_output) got_q.push_back({o_last, o_data});
    if (o_valid && !i_ready_output) stall_q.push_back({o_last, o_data});
    if (!i_ready_output && acc) stall_acc++;
    if (stall_left > 0) stall_left--;
    @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    logic acc;
    int   tries;
    tries = 0;
    if (rand_idle && $urandom_range(0, 1) == 1) cycle_step(1'b0, 1'b0, acc);
    do begin
      cycle_step(1'b1, b, acc);
      tries++;
    end while (!acc && tries < 200);
    if (!acc) begin
      errors++;
      $display("FAIL send_bit_timeout: not accepted after %0d cycles, want accept", tries);
    end
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int k = 7; k >= 0; k--) send_bit(v[k]);
  endtask

  task automatic send_word(input logic [31:0] v);
    for (int k = 31; k >= 0; k--) send_bit(v[k]);
  endtask

  task automatic flush();
    logic acc;
    repeat (4) cycle_step(1'b0, 1'b0, acc);
  endtask

  task automatic apply_reset();
    stall_left     = 0;
    i_reset        = 1'b1;
    i_valid_input  = 1'b0;
    i_data         = 1'b0;
    i_ready_output = 1'b1;
    @(negedge clk);
    i_reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (o_data !== 8'h00) begin errors++; $display("FAIL reset_o_data: got %h want 00", o_data); end
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_o_valid: got %b want 0", o_valid); end
    checks++; if (o_last !== 1'b0) begin errors++; $display("FAIL reset_o_last: got %b want 0", o_last); end
    checks++; if (o_lock !== 1'b0) begin errors++; $display("FAIL reset_o_lock: got %b want 0", o_lock); end
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_o_ready: got %b want 1", o_ready); end
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [7:0] b;
    logic [8:0] exp;
    got_q.delete();
    checks++; if (o_lock !== 1'b0) begin errors++; $display("FAIL basic_lock_pre: got %b want 0", o_lock); end
    send_word(PRE);
    checks++; if (o_lock !== 1'b1) begin errors++; $display("FAIL basic_lock_rise: got %b want 1", o_lock); end
    for (int i = 0; i < NBYTES - 1; i++) send_byte(pay_byte(0, i));
    b = pay_byte(0, NBYTES - 1);
    for (int k = 7; k >= 1; k--) send_bit(b[k]);
    checks++; if (o_lock !== 1'b1) begin errors++; $display("FAIL basic_lock_hold: got %b want 1", o_lock); end
    send_bit(b[0]);
    checks++; if (o_lock !== 1'b0) begin errors++; $display("FAIL basic_lock_fall: got %b want 0", o_lock); end
    flush();
    checks++; if (got_q.size() != NBYTES) begin errors++; $display("FAIL basic_count: got %0d want %0d", got_q.size(), NBYTES); end
    for (int i = 0; i < NBYTES; i++) begin
      exp = {i == NBYTES - 1, pay_byte(0, i)};
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp) begin
        errors++; $display("FAIL basic_byte[%0d]: got %h want %h", i, (i < got_q.size()) ? got_q[i] : 9'h1ff, exp);
      end
    end
  endtask

  task automatic test_sync_tol();
    logic [8:0] exp;
    got_q.delete();
    lock_seen = 1'b0;
    send_word(32'h5A3C_9E61);
    send_word(PRE ^ 32'h0000_0100);
`ifdef UNPACK_SYNC_TOL_EN
    checks++; if (o_lock !== 1'b1) begin errors++; $display("FAIL tol_lock: got %b want 1", o_lock); end
    for (int i = 0; i < NBYTES; i++) send_byte(pay_byte(0, i));
    flush();
    checks++; if (got_q.size() != NBYTES) begin errors++; $display("FAIL tol_count: got %0d want %0d", got_q.size(), NBYTES); end
    for (int i = 0; i < NBYTES; i++) begin
      exp = {i == NBYTES - 1, pay_byte(0, i)};
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp) begin
        errors++; $display("FAIL tol_byte[%0d]: got %h want %h", i, (i < got_q.size()) ? got_q[i] : 9'h1ff, exp);
      end
    end
`else
    for (int i = 0; i < 40; i++) send_bit(1'b0);
    flush();
    checks++; if (lock_seen !== 1'b0) begin errors++; $display("FAIL nolock_lock_seen: got %b want 0", lock_seen); end
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL nolock_count: got %0d want 0", got_q.size()); end
`endif
  endtask

  task automatic test_backpressure();
    logic [7:0] b;
    logic [8:0] exp;
    got_q.delete();
    stall_q.delete();
    stall_acc = 0;
    send_word(PRE);
    for (int i = 0; i < NBYTES; i++) begin
      b = pay_byte(0, i);
      for (int k = 7; k >= 0; k--) begin
        if (i == 10 && k == 7) stall_left = 20;
        send_bit(b[k]);
      end
    end
    flush();
    checks++; if (stall_acc != 7) begin errors++; $display("FAIL bp_bits_in_stall: got %0d want 7", stall_acc); end
    checks++; if (stall_q.size() != 20) begin errors++; $display("FAIL bp_stall_cycles: got %0d want 20", stall_q.size()); end
    checks++; if (stall_q.size() == 0 || stall_q[0] !== 9'h009) begin
      errors++; $display("FAIL bp_held_byte: got %h want 009", (stall_q.size() > 0) ? stall_q[0] : 9'h1ff);
    end
    for (int i = 1; i < stall_q.size(); i++) begin
      checks++;
      if (stall_q[i] !== 9'h009) begin errors++; $display("FAIL bp_stable[%0d]: got %h want 009", i, stall_q[i]); end
    end
    checks++; if (got_q.size() != NBYTES) begin errors++; $display("FAIL bp_count: got %0d want %0d", got_q.size(), NBYTES); end
    for (int i = 0; i < NBYTES; i++) begin
      exp = {i == NBYTES - 1, pay_byte(0, i)};
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp) begin
        errors++; $display("FAIL bp_byte[%0d]: got %h want %h", i, (i < got_q.size()) ? got_q[i] : 9'h1ff, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [8:0] exp;
    got_q.delete();
    send_word(PRE);
    for (int i = 0; i < NBYTES; i++) send_byte(pay_byte(1, i));
    send_word(PRE);
    for (int i = 0; i < NBYTES; i++) send_byte(pay_byte(0, i));
    flush();
    checks++; if (got_q.size() != 2 * NBYTES) begin errors++; $display("FAIL b2b_count: got %0d want %0d", got_q.size(), 2 * NBYTES); end
    for (int i = 0; i < 2 * NBYTES; i++) begin
      if (i < NBYTES) exp = {i == NBYTES - 1, pay_byte(1, i)};
      else            exp = {i == 2 * NBYTES - 1, pay_byte(0, i - NBYTES)};
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp) begin
        errors++; $display("FAIL b2b_byte[%0d]: got %h want %h", i, (i < got_q.size()) ? got_q[i] : 9'h1ff, exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] b;
    logic [8:0] exp;
    send_word(PRE);
    for (int i = 0; i < 62; i++) send_byte(pay_byte(0, i));
    stall_left = 10;
    b = pay_byte(0, 62);
    for (int k = 7; k >= 4; k--) send_bit(b[k]);
    apply_reset();
    checks++; if (o_data !== 8'h00) begin errors++; $display("FAIL mid_reset_o_data: got %h want 00", o_data); end
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_o_valid: got %b want 0", o_valid); end
    checks++; if (o_last !== 1'b0) begin errors++; $display("FAIL mid_reset_o_last: got %b want 0", o_last); end
    checks++; if (o_lock !== 1'b0) begin errors++; $display("FAIL mid_reset_o_lock: got %b want 0", o_lock); end
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL mid_reset_o_ready: got %b want 1", o_ready); end
    @(negedge clk);
    got_q.delete();
    send_word(PRE);
    for (int i = 0; i < NBYTES; i++) send_byte(pay_byte(0, i));
    flush();
    checks++; if (got_q.size() != NBYTES) begin errors++; $display("FAIL mid_count: got %0d want %0d", got_q.size(), NBYTES); end
    for (int i = 0; i < NBYTES; i++) begin
      exp = {i == NBYTES - 1, pay_byte(0, i)};
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp) begin
        errors++; $display("FAIL mid_byte[%0d]: got %h want %h", i, (i < got_q.size()) ? got_q[i] : 9'h1ff, exp);
      end
    end
  endtask

  task automatic test_valid_toggle();
    logic [8:0] exp;
    got_q.delete();
    rand_idle = 1'b1;
    send_word(PRE);
    for (int i = 0; i < NBYTES; i++) send_byte(pay_byte(0, i));
    rand_idle = 1'b0;
    flush();
    checks++; if (got_q.size() != NBYTES) begin errors++; $display("FAIL toggle_count: got %0d want %0d", got_q.size(), NBYTES); end
    for (int i = 0; i < NBYTES; i++) begin
      exp = {i == NBYTES - 1, pay_byte(0, i)};
      checks++;
      if (i >= got_q.size() || got_q[i] !== exp) begin
        errors++; $display("FAIL toggle_byte[%0d]: got %h want %h", i, (i < got_q.size()) ? got_q[i] : 9'h1ff, exp);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    i_reset        = 1'b1;
    i_data         = 1'b0;
    i_valid_input  = 1'b0;
    i_ready_output = 1'b1;
    @(negedge clk);
    test_reset();
    test_basic();
    test_sync_tol();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_valid_toggle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/unpack_stream.md
# unpack_stream

Receive-side counterpart of the packet transmitter. Accepts the serial bitstream, hunts for the 32-bit preamble, strips it, and reassembles the following payload bits into bytes delivered over a valid/ready byte interface. It sits between the serial line front-end and the byte-oriented consumer. It delimits each packet and flags its last byte.

## Interface
- SIZE_BIT_PACK, 1976, total packet bits, preamble included
- SIZE_PREAMBLE, 32, preamble length in bits
- PREAMBLE, 32'h1ACFFC1D, sync word, first-transmitted bit is MSB; must be nonzero
- SIZE_OUTPUT_BIT, 8, output byte width
- SYNC_TOL, 2, maximum preamble bit mismatches accepted (only with UNPACK_SYNC_TOL_EN)
- PAYLOAD_BITS, SIZE_BIT_PACK-SIZE_PREAMBLE (1944), derived; must be a multiple of SIZE_OUTPUT_BIT

Ports:
- i_clk  in  1  clock; all logic on rising edge
- i_reset  in  1  synchronous, active-high reset
- i_data  in  1  serial input bit
- i_valid_input  in  1  i_data valid
- o_ready  out  1  bit accepted when i_valid_input && o_ready
- o_data  out  8  assembled byte, first payload bit in bit 7
- o_valid  out  1  o_data valid
- i_ready_output  in  1  consumer accepts when o_valid && i_ready_output
- o_last  out  1  qualifies o_data as final byte of packet
- o_lock  out  1  high while in PAYLOAD state

## Operation
- States: HUNT, PAYLOAD.
- HUNT: each accepted bit shifts into 32-bit sync register at LSB. Match when register == PREAMBLE. Match → PAYLOAD, bit counter = 0, assembler cleared.
- PAYLOAD: each accepted bit shifts into byte assembler at LSB. Bit counter increments. Every 8th bit loads the byte into the output register and sets o_valid.
- Byte carrying the bit with counter == PAYLOAD_BITS-1 is loaded with o_last=1. State → HUNT, sync register cleared to 0.
- The sync register is cleared on every HUNT entry. A new preamble must arrive complete. No payload bit contributes to sync.
- Backpressure: o_ready=0 only when the output register holds an unaccepted byte (o_valid && !i_ready_output) and the assembler holds 7 bits. No bit is ever dropped. In HUNT, o_ready=1 unless the same condition holds for the pending last byte.
- Same-cycle accept and new byte completion: the register reloads with the new byte and o_valid stays 1.
- The input is ignored while i_valid_input=0 or o_ready=0. Counters hold.
- Bit counter width $clog2(PAYLOAD_BITS). Wrap is explicit via return to HUNT, never modular overflow.

## Timing
- Reset values:
  - o_data=0, o_valid=0, o_last=0, o_lock=0, o_ready=1
  - state HUNT; sync register, assembler and counter all 0
- Reset mid-packet discards the partial byte and the pending output byte.
- o_lock rises the cycle after the final preamble bit is accepted. It falls the cycle after the last payload bit is accepted.
- Byte latency: o_valid rises one cycle after the 8th bit of a byte is accepted. It falls one cycle after acceptance unless reloaded.
- Throughput: one bit per cycle sustained, given the consumer accepts within 7 cycles of o_valid.
- o_data and o_last are stable while o_valid && !i_ready_output.

## Configuration
- UNPACK_SYNC_TOL_EN defined: match when popcount(sync_reg ^ PREAMBLE) <= SYNC_TOL.
- Undefined: exact compare only. SYNC_TOL is ignored and no popcount logic is built.

## Structure
- Package unpack_pkg holds:
  - state enum (HUNT, PAYLOAD)
  - default PREAMBLE constant
  - SIZE_BIT_PACK and SIZE_PREAMBLE defaults
  - function computing PAYLOAD_BITS
- Sub-module unpack_sync_detect contains:
  - 32-bit shift register with clear input
  - comparator and optional popcount tolerance
  - single-cycle match output

## Test plan
- Preamble 1ACFFC1D, then 1944 bits forming bytes 0x00..0xF2, consumer always ready → 243 bytes 0x00..0xF2 in order. o_last only on 0xF2. o_lock high for exactly the payload span.
- Random bits then preamble with a 1-bit error → no lock without UNPACK_SYNC_TOL_EN. With it, lock and correct bytes.
- Consumer holds i_ready_output=0 for 20 cycles mid-packet → o_ready drops after 7 further bits. No bytes lost or duplicated. o_data stable while stalled.
- Two packets back-to-back, no gap → both fully delivered. Payload content equal to the preamble pattern causes no false relock.
- i_reset asserted at payload bit 500 → all outputs at reset values next cycle. A following clean packet is delivered intact.
- i_valid_input toggling 50% random → byte sequence identical to the continuous case.
